// File: rtl/pms_pkg.sv
// pms_pkg: shared definitions for the program management system.
//   fetch_state_t : instruction-fetch FSM states
//   pc_src_t      : pc_src selector codes
//   clog2         : ceiling log2 for parameter-derived widths
package pms_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      F_INSTR = 2'd1,
      F_IMM   = 2'd2
   } fetch_state_t;

   typedef enum logic [1:0] {
      PC_BR  = 2'd0,
      PC_JMP = 2'd1,
      PC_RET = 2'd2,
      PC_RST = 2'd3
   } pc_src_t;

   function automatic int unsigned clog2(input int unsigned value);
      int unsigned res;
      res = 0;
      while ((32'd1 << res) < value) res = res + 1;
      return res;
   endfunction

endpackage

// File: rtl/pms_dpram.sv
// pms_dpram: true dual-port synchronous RAM, read-first, write on port 2 only.
// Ports:
//   clk, rst_n        clock, async active-low reset (output registers only)
//   i_addr1/o_rdata1  port 1 read address / registered read data (reads every cycle)
//   i_addr2           port 2 address
//   i_wdata2/i_we2    port 2 write data / enable
//   i_re2/o_rdata2    port 2 read enable / registered read data (held when idle)
module pms_dpram #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned ADDR_W = 10
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] i_addr1,
   output logic [DATA_W-1:0] o_rdata1,
   input  logic [ADDR_W-1:0] i_addr2,
   input  logic [DATA_W-1:0] i_wdata2,
   input  logic              i_we2,
   input  logic              i_re2,
   output logic [DATA_W-1:0] o_rdata2
);

   localparam int unsigned DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [DATA_W-1:0] r_q1;
   logic [DATA_W-1:0] r_q2;

   // Array is never reset; contents survive reset.
   always_ff @(posedge clk) begin
      if (i_we2) r_mem[i_addr2] <= i_wdata2;
   end

   // Non-blocking reads sample the pre-write contents: read-first on both ports.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_q1 <= '0;
         r_q2 <= '0;
      end else begin
         r_q1 <= r_mem[i_addr1];
         if (i_re2) r_q2 <= r_mem[i_addr2];
      end
   end

   assign o_rdata1 = r_q1;
   assign o_rdata2 = r_q2;

endmodule

// File: rtl/pms_ras.sv
// pms_ras: program management system with PC, IR, immediate register,
// dual-port program/data memory and a circular return-address stack.
// Ports:
//   clk, reset_n                       clock, async active-low reset
//   fetch_req, imm_req                 fetch request (imm_req adds immediate word)
//   fetch_done, busy                   fetch completion pulse, FSM-not-idle
//   pc_update, pc_src, cond            PC update strobe, source select, branch qualifier
//   branch_off, jump_addr, restore_pc  PC targets
//   push_ra                            push current pc onto the RAS with pc_update
//   mem_addr2/wdata2/we2/re2/rdata2    data port of the memory
//   pc, ir, imm                        architectural registers
//   ra_top, ras_count                  RAS top entry / valid entries
//   ras_overflow, ras_underflow        sticky RAS status
module pms_ras
   import pms_pkg::*;
#(
   parameter int unsigned DATA_W    = 16,
   parameter int unsigned ADDR_W    = 10,
   parameter int unsigned RAS_DEPTH = 8,
   parameter int unsigned RESET_PC  = 0
) (
   input  logic                              clk,
   input  logic                              reset_n,
   input  logic                              fetch_req,
   input  logic                              imm_req,
   output logic                              fetch_done,
   output logic                              busy,
   input  logic                              pc_update,
   input  logic [1:0]                        pc_src,
   input  logic                              cond,
   input  logic [ADDR_W-1:0]                 branch_off,
   input  logic [ADDR_W-1:0]                 jump_addr,
   input  logic [ADDR_W-1:0]                 restore_pc,
   input  logic                              push_ra,
   input  logic [ADDR_W-1:0]                 mem_addr2,
   input  logic [DATA_W-1:0]                 mem_wdata2,
   input  logic                              mem_we2,
   input  logic                              mem_re2,
   output logic [DATA_W-1:0]                 mem_rdata2,
   output logic [ADDR_W-1:0]                 pc,
   output logic [DATA_W-1:0]                 ir,
   output logic [DATA_W-1:0]                 imm,
   output logic [ADDR_W-1:0]                 ra_top,
   output logic [clog2(RAS_DEPTH+1)-1:0]     ras_count,
   output logic                              ras_overflow,
   output logic                              ras_underflow
);

   localparam int unsigned        CNT_W      = clog2(RAS_DEPTH + 1);
   localparam int unsigned        PTR_W      = clog2(RAS_DEPTH);
   localparam logic [ADDR_W-1:0]  RST_PC_VAL = ADDR_W'(RESET_PC);
   localparam logic [ADDR_W-1:0]  PC_ONE     = ADDR_W'(1);
   localparam logic [PTR_W-1:0]   PTR_ONE    = PTR_W'(1);
   localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);
   localparam logic [CNT_W-1:0]   CNT_FULL   = CNT_W'(RAS_DEPTH);

   fetch_state_t      r_state, w_state_nxt;
   logic              r_imm_pend;
   logic              r_fetch_done;
   logic [ADDR_W-1:0] r_pc, w_pc_nxt, w_addr1;
   logic [DATA_W-1:0] r_ir, r_imm, w_rdata1;
   logic              w_start, w_ir_ld, w_imm_ld, w_done_nxt;
   logic              w_accept, w_push, w_pop;
   pc_src_t           w_src;

   logic [ADDR_W-1:0] r_ras [RAS_DEPTH];
   logic [PTR_W-1:0]  r_sp;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_ovf, r_unf;
   logic [ADDR_W-1:0] w_ra_top;

   pms_dpram #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_mem (
      .clk      (clk),
      .rst_n    (reset_n),
      .i_addr1  (w_addr1),
      .o_rdata1 (w_rdata1),
      .i_addr2  (mem_addr2),
      .i_wdata2 (mem_wdata2),
      .i_we2    (mem_we2),
      .i_re2    (mem_re2),
      .o_rdata2 (mem_rdata2)
   );

   // ---------------- fetch FSM ----------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= IDLE;
      else          r_state <= w_state_nxt;
   end

   // Port 1 reads pc while idle so the instruction word is ready in F_INSTR;
   // in F_INSTR it reads pc+1 so the immediate word is ready in F_IMM.
   always_comb begin
      w_state_nxt = r_state;
      w_start     = 1'b0;
      w_ir_ld     = 1'b0;
      w_imm_ld    = 1'b0;
      w_done_nxt  = 1'b0;
      w_addr1     = r_pc;
      case (r_state)
         IDLE: begin
            if (fetch_req && !pc_update) begin
               w_state_nxt = F_INSTR;
               w_start     = 1'b1;
            end
         end
         F_INSTR: begin
            w_addr1 = r_pc + PC_ONE;
            w_ir_ld = 1'b1;
            if (r_imm_pend) begin
               w_state_nxt = F_IMM;
            end else begin
               w_state_nxt = IDLE;
               w_done_nxt  = 1'b1;
            end
         end
         F_IMM: begin
            w_imm_ld    = 1'b1;
            w_state_nxt = IDLE;
            w_done_nxt  = 1'b1;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // ---------------- PC update ----------------
   assign w_src    = pc_src_t'(pc_src);
   assign w_accept = (r_state == IDLE) && pc_update;
   assign w_push   = w_accept && push_ra && (w_src != PC_RET);
   assign w_pop    = w_accept && (w_src == PC_RET);

   // ra_top already reads RESET_PC when empty, so a return on an empty
   // stack lands on RESET_PC without a separate path.
   always_comb begin
      w_pc_nxt = r_pc;
      if (w_ir_ld || w_imm_ld) begin
         w_pc_nxt = r_pc + PC_ONE;
      end else if (w_accept) begin
         case (w_src)
            PC_BR:   if (cond) w_pc_nxt = r_pc + branch_off;
            PC_JMP:  w_pc_nxt = jump_addr;
            PC_RET:  w_pc_nxt = w_ra_top;
            PC_RST:  w_pc_nxt = restore_pc;
            default: w_pc_nxt = r_pc;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_pc         <= RST_PC_VAL;
         r_ir         <= '0;
         r_imm        <= '0;
         r_imm_pend   <= 1'b0;
         r_fetch_done <= 1'b0;
      end else begin
         r_pc         <= w_pc_nxt;
         r_fetch_done <= w_done_nxt;
         if (w_start)  r_imm_pend <= imm_req;
         if (w_ir_ld)  r_ir       <= w_rdata1;
         if (w_imm_ld) r_imm      <= w_rdata1;
      end
   end

   // ---------------- return-address stack ----------------
   // r_sp is the next write slot; when full it points at the oldest entry,
   // so a push there overwrites it.
   always_ff @(posedge clk) begin
      if (w_push) r_ras[r_sp] <= r_pc;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sp  <= '0;
         r_cnt <= '0;
         r_ovf <= 1'b0;
         r_unf <= 1'b0;
      end else if (w_push) begin
         r_sp <= r_sp + PTR_ONE;
         if (r_cnt == CNT_FULL) r_ovf <= 1'b1;
         else                   r_cnt <= r_cnt + CNT_ONE;
      end else if (w_pop) begin
         if (r_cnt == '0) begin
            r_unf <= 1'b1;
         end else begin
            r_sp  <= r_sp - PTR_ONE;
            r_cnt <= r_cnt - CNT_ONE;
         end
      end
   end

   always_comb begin
      w_ra_top = RST_PC_VAL;
      if (r_cnt != '0) w_ra_top = r_ras[r_sp - PTR_ONE];
   end

   assign fetch_done    = r_fetch_done;
   assign busy          = (r_state != IDLE);
   assign pc            = r_pc;
   assign ir            = r_ir;
   assign imm           = r_imm;
   assign ra_top        = w_ra_top;
   assign ras_count     = r_cnt;
   assign ras_overflow  = r_ovf;
   assign ras_underflow = r_unf;

endmodule

// File: tb/tb_pms_ras.sv
// tb_pms_ras: self-checking bench for pms_ras against a queue/array model.
module tb_pms_ras;

   localparam int DW  = 16;
   localparam int AW  = 10;
   localparam int RD  = 8;
   localparam int RPC = 0;
   localparam int MSZ = 1 << AW;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          fetch_req, imm_req, fetch_done, busy;
   logic          pc_update, cond, push_ra;
   logic [1:0]    pc_src;
   logic [AW-1:0] branch_off, jump_addr, restore_pc, mem_addr2;
   logic [DW-1:0] mem_wdata2, mem_rdata2;
   logic          mem_we2, mem_re2;
   logic [AW-1:0] pc, ra_top;
   logic [DW-1:0] ir, imm;
   logic [3:0]    ras_count;
   logic          ras_overflow, ras_underflow;

   always #5 clk = ~clk;

   pms_ras #(
      .DATA_W    (DW),
      .ADDR_W    (AW),
      .RAS_DEPTH (RD),
      .RESET_PC  (RPC)
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .fetch_req     (fetch_req),
      .imm_req       (imm_req),
      .fetch_done    (fetch_done),
      .busy          (busy),
      .pc_update     (pc_update),
      .pc_src        (pc_src),
      .cond          (cond),
      .branch_off    (branch_off),
      .jump_addr     (jump_addr),
      .restore_pc    (restore_pc),
      .push_ra       (push_ra),
      .mem_addr2     (mem_addr2),
      .mem_wdata2    (mem_wdata2),
      .mem_we2       (mem_we2),
      .mem_re2       (mem_re2),
      .mem_rdata2    (mem_rdata2),
      .pc            (pc),
      .ir            (ir),
      .imm           (imm),
      .ra_top        (ra_top),
      .ras_count     (ras_count),
      .ras_overflow  (ras_overflow),
      .ras_underflow (ras_underflow)
   );

   int n_checks = 0;
   int n_errors = 0;

   // reference model
   int m_mem [MSZ];
   int m_pc, m_imm;
   int m_ras [$];
   bit m_ovf, m_unf;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int m_top();
      if (m_ras.size() == 0) return RPC;
      return m_ras[m_ras.size()-1];
   endfunction

   task automatic model_pc(input int src, input bit c, input int off,
                           input int ja, input int ra, input bit push);
      int target, so;
      target = m_pc;
      case (src)
         0: begin
            so = (off >= MSZ/2) ? off - MSZ : off;
            if (c) target = (((m_pc + so) % MSZ) + MSZ) % MSZ;
         end
         1: target = ja;
         2: begin
            if (m_ras.size() == 0) begin
               target = RPC;
               m_unf  = 1'b1;
            end else begin
               target = m_ras.pop_back();
            end
         end
         default: target = ra;
      endcase
      if (push && src != 2) begin
         if (m_ras.size() == RD) begin
            void'(m_ras.pop_front());
            m_ovf = 1'b1;
         end
         m_ras.push_back(m_pc);
      end
      m_pc = target;
   endtask

   task automatic do_pc(input int src, input bit c, input int off,
                        input int ja, input int ra, input bit push);
      pc_update  = 1'b1;
      pc_src     = 2'(src);
      cond       = c;
      branch_off = AW'(off);
      jump_addr  = AW'(ja);
      restore_pc = AW'(ra);
      push_ra    = push;
      tick();
      pc_update  = 1'b0;
      push_ra    = 1'b0;
      model_pc(src, c, off, ja, ra, push);
   endtask

   task automatic wr2(input int a, input int d);
      mem_addr2  = AW'(a);
      mem_wdata2 = DW'(d);
      mem_we2    = 1'b1;
      tick();
      mem_we2    = 1'b0;
      m_mem[a]   = d;
   endtask

   task automatic model_reset();
      m_pc  = RPC;
      m_imm = 0;
      m_ras.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      tick();
      tick();
      model_reset();
      n_checks++; if (pc !== AW'(RPC)) begin n_errors++; $display("FAIL reset_pc: got %0d expected %0d", pc, RPC); end
      n_checks++; if (ir !== '0 || imm !== '0) begin n_errors++; $display("FAIL reset_ir_imm: got %0h/%0h expected 0/0", ir, imm); end
      n_checks++; if (mem_rdata2 !== '0) begin n_errors++; $display("FAIL reset_rdata2: got %0h expected 0", mem_rdata2); end
      n_checks++; if (busy !== 1'b0 || fetch_done !== 1'b0) begin n_errors++; $display("FAIL reset_fsm: got busy=%b done=%b expected 0/0", busy, fetch_done); end
      n_checks++; if (ras_count !== '0 || ras_overflow !== 1'b0 || ras_underflow !== 1'b0) begin n_errors++; $display("FAIL reset_ras: got cnt=%0d ovf=%b unf=%b expected 0/0/0", ras_count, ras_overflow, ras_underflow); end
      n_checks++; if (ra_top !== AW'(RPC)) begin n_errors++; $display("FAIL reset_ra_top: got %0d expected %0d", ra_top, RPC); end
      reset_n = 1'b1;
      tick();
   endtask

   task automatic test_preload();
      int a;
      for (int i = 0; i < MSZ; i++) wr2(i, (i < 100) ? i + 1 : int'($urandom_range(0, 65535)));
      for (int k = 0; k < 8; k++) begin
         a = int'($urandom_range(0, MSZ-1));
         mem_addr2 = AW'(a);
         mem_re2   = 1'b1;
         tick();
         mem_re2   = 1'b0;
         mem_addr2 = AW'((a + 1) % MSZ);
         n_checks++; if (mem_rdata2 !== DW'(m_mem[a])) begin n_errors++; $display("FAIL port2_read[%0d]: got %0h expected %0h", a, mem_rdata2, m_mem[a]); end
         tick();
         n_checks++; if (mem_rdata2 !== DW'(m_mem[a])) begin n_errors++; $display("FAIL port2_hold[%0d]: got %0h expected %0h", a, mem_rdata2, m_mem[a]); end
      end
   endtask

   task automatic test_fetch_stream();
      int n, cyc;
      bit prev;
      n = 0; cyc = 0; prev = 1'b0;
      fetch_req = 1'b1;
      imm_req   = 1'b0;
      while (n < 100 && cyc < 500) begin
         tick();
         cyc++;
         if (fetch_done) begin
            n++;
            n_checks++; if (ir !== DW'(m_mem[m_pc])) begin n_errors++; $display("FAIL stream_ir[%0d]: got %0d expected %0d", n, ir, m_mem[m_pc]); end
            n_checks++; if (prev) begin n_errors++; $display("FAIL stream_done_pulse[%0d]: got 2-cycle pulse expected 1", n); end
            m_pc = (m_pc + 1) % MSZ;
            if (n == 100) fetch_req = 1'b0;
         end
         prev = fetch_done;
      end
      fetch_req = 1'b0;
      tick();
      n_checks++; if (n != 100) begin n_errors++; $display("FAIL stream_count: got %0d expected 100", n); end
      n_checks++; if (pc !== AW'(100)) begin n_errors++; $display("FAIL stream_pc: got %0d expected 100", pc); end
      n_checks++; if (busy !== 1'b0 || fetch_done !== 1'b0) begin n_errors++; $display("FAIL stream_idle: got busy=%b done=%b expected 0/0", busy, fetch_done); end
   endtask

   task automatic test_imm_fetch();
      int edges;
      wr2(5, 'h1234);
      wr2(6, 'hBEEF);
      do_pc(1, 1'b0, 0, 5, 0, 1'b0);
      n_checks++; if (pc !== AW'(5)) begin n_errors++; $display("FAIL imm_jump_pc: got %0d expected 5", pc); end
      fetch_req = 1'b1;
      imm_req   = 1'b1;
      tick();
      fetch_req = 1'b0;
      imm_req   = 1'b0;
      edges = 1;
      n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL imm_busy: got %b expected 1", busy); end
      while (!fetch_done && edges < 10) begin tick(); edges++; end
      n_checks++; if (edges != 3) begin n_errors++; $display("FAIL imm_latency: got %0d edges expected 3", edges); end
      n_checks++; if (ir !== 16'h1234) begin n_errors++; $display("FAIL imm_ir: got %0h expected 1234", ir); end
      n_checks++; if (imm !== 16'hBEEF) begin n_errors++; $display("FAIL imm_imm: got %0h expected beef", imm); end
      n_checks++; if (pc !== AW'(7)) begin n_errors++; $display("FAIL imm_pc: got %0d expected 7", pc); end
      m_pc = 7; m_imm = 'hBEEF;
      tick();
   endtask

   task automatic test_branch();
      do_pc(3, 1'b0, 0, 0, 20, 1'b0);
      do_pc(0, 1'b1, MSZ - 4, 0, 0, 1'b0);
      n_checks++; if (pc !== AW'(16)) begin n_errors++; $display("FAIL branch_taken: got %0d expected 16", pc); end
      do_pc(3, 1'b0, 0, 0, 20, 1'b0);
      do_pc(0, 1'b0, MSZ - 4, 0, 0, 1'b0);
      n_checks++; if (pc !== AW'(20)) begin n_errors++; $display("FAIL branch_not_taken: got %0d expected 20", pc); end
      do_pc(3, 1'b0, 0, 0, 1020, 1'b0);
      do_pc(0, 1'b1, 10, 0, 0, 1'b0);
      n_checks++; if (pc !== AW'(6)) begin n_errors++; $display("FAIL branch_wrap: got %0d expected 6", pc); end
   endtask

   task automatic test_call_return();
      do_pc(3, 1'b0, 0, 0, 40, 1'b0);
      do_pc(1, 1'b0, 0, 100, 0, 1'b1);
      n_checks++; if (pc !== AW'(100) || ras_count !== 4'd1 || ra_top !== AW'(40)) begin n_errors++; $display("FAIL call: got pc=%0d cnt=%0d top=%0d expected 100/1/40", pc, ras_count, ra_top); end
      do_pc(2, 1'b0, 0, 0, 0, 1'b1);
      n_checks++; if (pc !== AW'(40) || ras_count !== 4'd0) begin n_errors++; $display("FAIL return: got pc=%0d cnt=%0d expected 40/0", pc, ras_count); end
      for (int i = 0; i < 9; i++) begin
         do_pc(3, 1'b0, 0, 0, 100 + i*10, 1'b0);
         do_pc(1, 1'b0, 0, 500 + i, 0, 1'b1);
         if (i == 7) begin
            n_checks++; if (ras_overflow !== 1'b0 || ras_count !== 4'd8) begin n_errors++; $display("FAIL ras_full: got ovf=%b cnt=%0d expected 0/8", ras_overflow, ras_count); end
         end
      end
      n_checks++; if (ras_overflow !== 1'b1 || ras_count !== 4'd8 || ra_top !== AW'(180)) begin n_errors++; $display("FAIL ras_overflow: got ovf=%b cnt=%0d top=%0d expected 1/8/180", ras_overflow, ras_count, ra_top); end
      for (int i = 0; i < 9; i++) begin
         do_pc(2, 1'b0, 0, 0, 0, 1'b0);
         n_checks++; if (pc !== AW'((i < 8) ? 100 + (8 - i)*10 : RPC)) begin n_errors++; $display("FAIL ret_seq[%0d]: got %0d expected %0d", i, pc, (i < 8) ? 100 + (8 - i)*10 : RPC); end
         if (i == 7) begin
            n_checks++; if (ras_underflow !== 1'b0 || ras_count !== 4'd0) begin n_errors++; $display("FAIL ras_empty: got unf=%b cnt=%0d expected 0/0", ras_underflow, ras_count); end
         end
      end
      n_checks++; if (ras_underflow !== 1'b1 || ras_count !== 4'd0 || ras_overflow !== 1'b1) begin n_errors++; $display("FAIL ras_underflow: got unf=%b cnt=%0d ovf=%b expected 1/0/1", ras_underflow, ras_count, ras_overflow); end
   endtask

   task automatic test_contention();
      pc_update = 1'b1; pc_src = 2'd1; jump_addr = AW'(50); push_ra = 1'b0;
      fetch_req = 1'b1; imm_req = 1'b0;
      tick();
      pc_update = 1'b0;
      model_pc(1, 1'b0, 0, 50, 0, 1'b0);
      n_checks++; if (pc !== AW'(50) || busy !== 1'b0) begin n_errors++; $display("FAIL contend_defer: got pc=%0d busy=%b expected 50/0", pc, busy); end
      tick();
      fetch_req = 1'b0;
      n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL contend_start: got busy=%b expected 1", busy); end
      // pc_update while busy must be ignored
      pc_update = 1'b1; pc_src = 2'd1; jump_addr = AW'(300);
      tick();
      pc_update = 1'b0;
      n_checks++; if (fetch_done !== 1'b1 || ir !== DW'(m_mem[50]) || pc !== AW'(51)) begin n_errors++; $display("FAIL contend_fetch: got done=%b ir=%0h pc=%0d expected 1/%0h/51", fetch_done, ir, pc, m_mem[50]); end
      m_pc = 51;
      tick();
      n_checks++; if (fetch_done !== 1'b0 || pc !== AW'(51)) begin n_errors++; $display("FAIL contend_after: got done=%b pc=%0d expected 0/51", fetch_done, pc); end
   endtask

   task automatic test_read_first();
      int old, nw;
      do_pc(1, 1'b0, 0, 60, 0, 1'b0);
      old = m_mem[60];
      nw  = (old + 16'h5A5A) & 16'hFFFF;
      fetch_req = 1'b1; imm_req = 1'b0;
      mem_addr2 = AW'(60); mem_wdata2 = DW'(nw); mem_we2 = 1'b1;
      tick();
      fetch_req = 1'b0; mem_we2 = 1'b0;
      tick();
      n_checks++; if (fetch_done !== 1'b1 || ir !== DW'(old)) begin n_errors++; $display("FAIL read_first: got done=%b ir=%0h expected 1/%0h", fetch_done, ir, old); end
      m_mem[60] = nw; m_pc = 61;
      mem_re2 = 1'b1;
      tick();
      mem_re2 = 1'b0;
      n_checks++; if (mem_rdata2 !== DW'(nw)) begin n_errors++; $display("FAIL read_first_new: got %0h expected %0h", mem_rdata2, nw); end
   endtask

   task automatic test_random();
      int op, a, d, edges, ei, eimm;
      bit im;
      for (int it = 0; it < 150; it++) begin
         op = int'($urandom_range(0, 3));
         if (op <= 1) begin
            do_pc(int'($urandom_range(0, 3)), 1'($urandom), int'($urandom_range(0, MSZ-1)),
                  int'($urandom_range(0, MSZ-1)), int'($urandom_range(0, MSZ-1)), 1'($urandom));
         end else if (op == 2) begin
            im = 1'($urandom);
            ei = m_mem[m_pc];
            m_pc = (m_pc + 1) % MSZ;
            if (im) begin m_imm = m_mem[m_pc]; m_pc = (m_pc + 1) % MSZ; end
            eimm = m_imm;
            fetch_req = 1'b1; imm_req = im;
            tick();
            fetch_req = 1'b0; imm_req = 1'b0;
            edges = 1;
            while (!fetch_done && edges < 10) begin tick(); edges++; end
            n_checks++; if (edges != (im ? 3 : 2)) begin n_errors++; $display("FAIL rnd_latency[%0d]: got %0d expected %0d", it, edges, im ? 3 : 2); end
            n_checks++; if (ir !== DW'(ei) || imm !== DW'(eimm)) begin n_errors++; $display("FAIL rnd_fetch[%0d]: got %0h/%0h expected %0h/%0h", it, ir, imm, ei, eimm); end
            tick();
         end else begin
            a = int'($urandom_range(0, MSZ-1));
            d = int'($urandom_range(0, 65535));
            wr2(a, d);
            mem_re2 = 1'b1;
            tick();
            mem_re2 = 1'b0;
            n_checks++; if (mem_rdata2 !== DW'(d)) begin n_errors++; $display("FAIL rnd_port2[%0d]: got %0h expected %0h", it, mem_rdata2, d); end
         end
         n_checks++; if (pc !== AW'(m_pc)) begin n_errors++; $display("FAIL rnd_pc[%0d]: got %0d expected %0d", it, pc, m_pc); end
         n_checks++; if (ras_count !== 4'(m_ras.size()) || ra_top !== AW'(m_top())) begin n_errors++; $display("FAIL rnd_ras[%0d]: got cnt=%0d top=%0d expected %0d/%0d", it, ras_count, ra_top, m_ras.size(), m_top()); end
         n_checks++; if (ras_overflow !== m_ovf || ras_underflow !== m_unf) begin n_errors++; $display("FAIL rnd_flags[%0d]: got %b%b expected %b%b", it, ras_overflow, ras_underflow, m_ovf, m_unf); end
      end
   endtask

   task automatic test_reset_mid_fetch();
      int seen;
      do_pc(1, 1'b0, 0, 200, 0, 1'b0);
      fetch_req = 1'b1; imm_req = 1'b1;
      tick();
      fetch_req = 1'b0; imm_req = 1'b0;
      tick();
      n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL midrst_busy: got %b expected 1", busy); end
      #2 reset_n = 1'b0;
      #1;
      model_reset();
      n_checks++; if (pc !== AW'(RPC) || ir !== '0 || imm !== '0) begin n_errors++; $display("FAIL midrst_regs: got pc=%0d ir=%0h imm=%0h expected %0d/0/0", pc, ir, imm, RPC); end
      n_checks++; if (busy !== 1'b0 || fetch_done !== 1'b0) begin n_errors++; $display("FAIL midrst_fsm: got busy=%b done=%b expected 0/0", busy, fetch_done); end
      n_checks++; if (ras_count !== '0 || ras_overflow !== 1'b0 || ras_underflow !== 1'b0) begin n_errors++; $display("FAIL midrst_ras: got cnt=%0d ovf=%b unf=%b expected 0/0/0", ras_count, ras_overflow, ras_underflow); end
      seen = 0;
      for (int i = 0; i < 3; i++) begin tick(); if (fetch_done) seen++; end
      reset_n = 1'b1;
      for (int i = 0; i < 3; i++) begin tick(); if (fetch_done) seen++; end
      n_checks++; if (seen != 0) begin n_errors++; $display("FAIL midrst_no_done: got %0d pulses expected 0", seen); end
      mem_addr2 = AW'(6); mem_re2 = 1'b1;
      tick();
      mem_re2 = 1'b0;
      n_checks++; if (mem_rdata2 !== DW'(m_mem[6])) begin n_errors++; $display("FAIL midrst_mem_kept: got %0h expected %0h", mem_rdata2, m_mem[6]); end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

   initial begin
      reset_n = 1'b0;
      fetch_req = 1'b0; imm_req = 1'b0;
      pc_update = 1'b0; pc_src = 2'd0; cond = 1'b0; push_ra = 1'b0;
      branch_off = '0; jump_addr = '0; restore_pc = '0;
      mem_addr2 = '0; mem_wdata2 = '0; mem_we2 = 1'b0; mem_re2 = 1'b0;
      model_reset();
      test_reset();
      test_preload();
      test_fetch_stream();
      test_imm_fetch();
      test_branch();
      test_call_return();
      test_contention();
      test_read_first();
      test_random();
      test_reset_mid_fetch();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
